stump_alu_seq: RTL and testbench
================================

Name: stump_alu_seq

Overview:
- Parametrised, registered successor to the combinational Stump ALU.
- Performs ADD/ADC/SUB/SBC/AND/OR, plus an iterative multi-cycle multiply, with a valid/ready handshake.
- Holds the architectural NZVC flag register internally; writes are gated by a per-operation set-flags bit.
- Sits between the register-file read stage and write-back in the Stump datapath.

Parameters:
- WIDTH, 16: operand/result width in bits (≥4).
- MUL_CNT_W, $clog2(WIDTH+1): width of the multiply iteration counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request (high only in IDLE)
- func  input  3  000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 AND, 101 OR, 110 MUL, 111 MOV (pass operand_B)
- operand_A  input  WIDTH  first operand
- operand_B  input  WIDTH  second operand
- csh  input  1  carry from shifter, used as C for AND/OR/MOV
- set_flags  input  1  write NZVC on completion
- out_valid  output  1  one-cycle pulse: result valid
- result  output  WIDTH  registered result, held until next completion
- flags  output  4  architectural flag register {N,Z,V,C}; also the carry-in source

Behaviour:
- Reset (rst=0, async): state=IDLE; result=0; flags=4'b0000; out_valid=0; in_ready=1 after release; multiplier state cleared.
- Reset asserted mid-MUL aborts the operation: no out_valid, no flag write.
- Accept rule: a request is accepted on a rising edge with in_valid && in_ready. Operands, func and set_flags are latched on accept.
- Inputs are ignored while in_ready=0; there is no queueing.
- c_in is flags[0] as sampled at accept. A flag write in the same edge does not affect the op being accepted.
- States:
  - IDLE: on accept of func≠110 → DONE; on accept of 110 → MUL.
  - MUL: one shift-add step per cycle for WIDTH cycles, counter counts down from WIDTH; at count 0 → DONE.
  - DONE: for one cycle out_valid=1, result and flags updated, in_ready=0; → IDLE.
- Latency (accept edge to out_valid high): single-cycle ops 1 cycle; MUL WIDTH+1 cycles.
- Throughput: one single-cycle op per 2 cycles.
- Arithmetic is carried out at WIDTH+1 bits; C = bit WIDTH of the sum.
  - ADD: A+B.
  - ADC: A+B+c_in.
  - SUB: A+~B+1.
  - SBC: A+~B+c_in.
- V for ADD/ADC: (A[msb]==B[msb]) && (R[msb]≠A[msb]).
- V for SUB/SBC: the same rule with ~B in place of B.
- AND/OR/MOV: V=0, C=csh latched at accept.
- MUL: unsigned, result = low WIDTH bits of A*B; C=1 iff the high WIDTH bits are nonzero; V=0.
- All ops: N=R[msb]; Z=(R==0).
- Flags are written only in DONE and only if the latched set_flags=1. Otherwise flags hold their value; result is always updated.
- Wrap-around: ADD of max+1 gives result 0, C=1, Z=1.

Optional Feature:
- Macro STUMP_ALU_MUL_EN.
- Defined: func 110 is the iterative multiply above; the stump_mul_seq instance is present.
- Undefined: no multiplier logic, and the MUL state is unreachable. func 110 behaves as MOV (result=B, 1-cycle latency, V=0, C=csh).

Decomposition:
- Package stump_alu_pkg:
  - func encoding localparams (FN_ADD … FN_MOV);
  - flag index constants (FLG_N=3, FLG_Z=2, FLG_V=1, FLG_C=0);
  - state enum {ST_IDLE, ST_MUL, ST_DONE}.
- Sub-module stump_mul_seq:
  - WIDTH-parametrised shift-add multiplier with start/busy/done and a 2*WIDTH product.
  - Instantiated only under STUMP_ALU_MUL_EN.

Test Plan:
- Reset mid-MUL (WIDTH=16): A=7, B=9, MUL accepted; rst low at cycle 5 → no out_valid, flags=0000, in_ready=1 after release.
- ADD 16'hFFFF+16'h0001, set_flags=1 → out_valid 1 cycle after accept, result=0000, flags=0101 (Z,C).
- SUB 16'h8000-16'h0001, set_flags=1 → result=7FFF, flags=0011 (V,C).
- ADC chain with flags C=1: ADC 16'h0001+16'h0001 → result=0003; repeated with set_flags=0 → flags unchanged.
- MUL 16'h0100×16'h0100 (macro on) → out_valid 17 cycles after accept, result=0000, flags=0101. The same op with macro off → result=0100 after 1 cycle, C=csh.
- in_valid held high through 3 back-to-back ORs → accepted on alternate edges only, 3 out_valid pulses, in_ready=0 during DONE.

Source files
------------

// File: rtl/stump_alu_pkg.sv
// stump_alu_pkg: shared encodings for the registered Stump ALU.
`default_nettype none

package stump_alu_pkg;

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_ADC = 3'b001;
  localparam logic [2:0] FN_SUB = 3'b010;
  localparam logic [2:0] FN_SBC = 3'b011;
  localparam logic [2:0] FN_AND = 3'b100;
  localparam logic [2:0] FN_OR  = 3'b101;
  localparam logic [2:0] FN_MUL = 3'b110;
  localparam logic [2:0] FN_MOV = 3'b111;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/stump_mul_seq.sv
// stump_mul_seq: iterative shift-add unsigned multiplier, one partial product per cycle.
`default_nettype none

module stump_mul_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = CNT_W'(WIDTH);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == '0);
  assign product = acc_q;

endmodule

`default_nettype wire

// File: rtl/stump_alu_seq.sv
// stump_alu_seq: registered Stump ALU with NZVC flag register and valid/ready handshake.
// Define STUMP_ALU_MUL_EN to build the iterative multiplier for func 110 (otherwise 110 acts as MOV).
`default_nettype none

module stump_alu_seq
  import stump_alu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MUL_CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  input  logic             csh,
  input  logic             set_flags,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH-1:0] bx, alu_res;
  logic [WIDTH:0]   sum;
  logic             cy, arith, alu_c, alu_v;
  logic [3:0]       alu_flags;

  // Single-cycle ops are evaluated straight from the accepted inputs, so the
  // carry-in is the flag register value before any write on the accept edge.
  always_comb begin
    bx    = operand_B;
    cy    = 1'b0;
    arith = 1'b1;
    case (func)
      FN_ADC:  cy = flags_q[FLG_C];
      FN_SUB:  begin bx = ~operand_B; cy = 1'b1; end
      FN_SBC:  begin bx = ~operand_B; cy = flags_q[FLG_C]; end
      FN_ADD:  arith = 1'b1;
      default: arith = 1'b0;
    endcase
    sum = {1'b0, operand_A} + {1'b0, bx} + {{WIDTH{1'b0}}, cy};
    case (func)
      FN_AND:  alu_res = operand_A & operand_B;
      FN_OR:   alu_res = operand_A | operand_B;
      default: alu_res = arith ? sum[WIDTH-1:0] : operand_B;
    endcase
    alu_c = arith ? sum[WIDTH] : csh;
    alu_v = arith && (operand_A[WIDTH-1] == bx[WIDTH-1])
                  && (sum[WIDTH-1] != operand_A[WIDTH-1]);
    alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_v, alu_c};
  end

`ifdef STUMP_ALU_MUL_EN
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic               sf_q, sf_d;

  stump_mul_seq #(
    .WIDTH (WIDTH),
    .CNT_W (MUL_CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (operand_A),
    .b       (operand_B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
`ifdef STUMP_ALU_MUL_EN
    mul_start = 1'b0;
    sf_d      = sf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef STUMP_ALU_MUL_EN
          sf_d = set_flags;
          if (func == FN_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else
`endif
          begin
            result_d = alu_res;
            if (set_flags) flags_d = alu_flags;
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL: begin
`ifdef STUMP_ALU_MUL_EN
        if (mul_done && mul_busy) begin
          result_d = mul_prod[WIDTH-1:0];
          if (sf_q) begin
            flags_d = {mul_prod[WIDTH-1], (mul_prod[WIDTH-1:0] == '0), 1'b0,
                       (mul_prod[2*WIDTH-1:WIDTH] != '0)};
          end
          state_d = ST_DONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

`ifdef STUMP_ALU_MUL_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sf_q <= 1'b0;
    else      sf_q <= sf_d;
  end
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_stump_alu_seq.sv
// tb_stump_alu_seq: directed and random checks of stump_alu_seq against an arithmetic model.
`default_nettype none

module tb_stump_alu_seq;

`ifdef STUMP_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  func = 3'b000;
  logic [15:0] operand_A = '0;
  logic [15:0] operand_B = '0;
  logic        csh = 1'b0;
  logic        set_flags = 1'b0;
  logic        out_valid;
  logic [15:0] result;
  logic [3:0]  flags;

  int n_assert = 0;
  int n_fail   = 0;
  logic [3:0] m_flags = 4'b0000;

  stump_alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func      (func),
    .operand_A (operand_A),
    .operand_B (operand_B),
    .csh       (csh),
    .set_flags (set_flags),
    .out_valid (out_valid),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned sum for C, signed integer sum for V.
  task automatic model(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic sf,
                       output logic [15:0] r, output logic [3:0] fl);
    int     u, sr;
    longint p;
    logic   cin, nc, nv;
    cin = m_flags[0];
    u = 0; sr = 0; nc = c; nv = 1'b0; r = b;
    case (f)
      3'd0: begin u = int'(a) + int'(b);                sr = int'($signed(a)) + int'($signed(b)); end
      3'd1: begin u = int'(a) + int'(b) + int'(cin);    sr = int'($signed(a)) + int'($signed(b)) + int'(cin); end
      3'd2: begin u = int'(a) + (65535 - int'(b)) + 1;  sr = int'($signed(a)) - int'($signed(b)); end
      3'd3: begin u = int'(a) + (65535 - int'(b)) + int'(cin);
                  sr = int'($signed(a)) - int'($signed(b)) - 1 + int'(cin); end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: if (MUL_EN) begin
              p  = longint'(a) * longint'(b);
              r  = p[15:0];
              nc = (p >> 16) != 0;
            end
      default: r = b;
    endcase
    if (f <= 3'd3) begin
      r  = u[15:0];
      nc = (u >> 16) != 0;
      nv = (sr > 32767) || (sr < -32768);
    end
    fl = {r[15], r == 16'h0, nv, nc};
    if (sf) m_flags = fl;
    fl = m_flags;
  endtask

  task automatic run_op(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic sf);
    logic [15:0] er;
    logic [3:0]  ef;
    int lat, elat;
    model(f, a, b, c, sf, er, ef);
    elat = (MUL_EN && f == 3'd6) ? 17 : 1;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; func = f; operand_A = a; operand_B = b; csh = c; set_flags = sf;
    @(negedge clk);
    in_valid = 1'b0; func = 3'($urandom); operand_A = 16'($urandom);
    operand_B = 16'($urandom); csh = 1'($urandom); set_flags = 1'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("result", 32'(result), 32'(er));
    chk("flags", 32'(flags), 32'(ef));
    chk("in_ready_done", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("out_valid_pulse", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] er, ra, rb;
    logic [3:0]  ef;
    int pulses;

    #1;
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    chk("add_wrap_flags", 32'(flags), 32'h5);
    run_op(3'd2, 16'h8000, 16'h0001, 1'b0, 1'b1);
    chk("sub_flags", 32'(flags), 32'h3);
    run_op(3'd1, 16'h0001, 16'h0001, 1'b0, 1'b0);
    chk("adc_nosf_result", 32'(result), 32'h3);
    chk("adc_nosf_flags", 32'(flags), 32'h3);
    run_op(3'd1, 16'h0001, 16'h0001, 1'b0, 1'b1);
    chk("adc_sf_result", 32'(result), 32'h3);
    run_op(3'd6, 16'h0100, 16'h0100, 1'b1, 1'b1);
    run_op(3'd3, 16'h0005, 16'h0007, 1'b0, 1'b1);

    // in_valid held high across three ORs
    model(3'd5, 16'h00F0, 16'h0F00, 1'b1, 1'b1, er, ef);
    @(negedge clk);
    in_valid = 1'b1; func = 3'd5; operand_A = 16'h00F0; operand_B = 16'h0F00;
    csh = 1'b1; set_flags = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("b2b_out_valid", 32'(out_valid), 32'(i % 2));
      chk("b2b_in_ready", 32'(in_ready), 32'((i + 1) % 2));
      if (out_valid === 1'b1) begin
        pulses++;
        chk("b2b_result", 32'(result), 32'(er));
        chk("b2b_flags", 32'(flags), 32'(ef));
      end
      if (i == 5) in_valid = 1'b0;
    end
    chk("b2b_pulses", 32'(pulses), 32'd3);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: ra = 16'hFFFF;
        1: ra = 16'h8000;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: rb = 16'h0000;
        1: rb = 16'h7FFF;
        default: rb = 16'($urandom);
      endcase
      run_op(3'($urandom_range(0, 7)), ra, rb, 1'($urandom), 1'($urandom));
    end

    // Reset during an operation in flight
    @(negedge clk);
    in_valid = 1'b1; func = MUL_EN ? 3'd6 : 3'd0; operand_A = 16'd7; operand_B = 16'd9;
    set_flags = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    m_flags = 4'b0000;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_flags", 32'(flags), 32'h0);
    chk("midrst_result", 32'(result), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    chk("midrst_no_out_valid", 32'(pulses), 32'd0);
    chk("midrst_flags_hold", 32'(flags), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
